pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-address width.
REQ-002 SHALL have parameter MDU_LAT, default 4, multiply/divide unit latency in cycles, legal range 1..15.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports rs_d, rt_d  input  REG_W  decode-stage source registers.
REQ-007 SHALL have ports rs_e, rt_e  input  REG_W  execute-stage source registers.
REQ-008 SHALL have ports wreg_e, wreg_m, wreg_w  input  REG_W  destination registers in E, M and W.
REQ-009 SHALL have ports regwrite_e, regwrite_m, regwrite_w  input  1  register-write valid in E, M and W.
REQ-010 SHALL have ports memtoreg_e, memtoreg_m  input  1  load in E and M.
REQ-011 SHALL have ports branch_d, pcsrc_d  input  1  branch in D, and branch taken.
REQ-012 SHALL have port mdu_use_d  input  1  D instruction is mult/div/mfhi/mflo.
REQ-013 SHALL have port mdu_start_e  input  1  mult/div enters E this cycle.
REQ-014 SHALL have ports stall_f, stall_d, flush_d, flush_e  output  1  pipeline control.
REQ-015 SHALL have ports fwd_a_d, fwd_b_d  output  1  D-stage forward from M.
REQ-016 SHALL have ports fwd_a_e, fwd_b_e  output  2  E-stage operand select: 00 register file, 01 W, 10 M.
REQ-017 SHALL have port mdu_busy  output  1  MDU in progress.

Function
REQ-018 SHALL drive fwd_a_e=10 when rs_e!=0, regwrite_m=1 and wreg_m==rs_e; else 01 when rs_e!=0, regwrite_w=1 and wreg_w==rs_e; else 00. M SHALL win over W. fwd_b_e SHALL use the same rule with rt_e.
REQ-019 SHALL drive fwd_a_d=1 when rs_d!=0, regwrite_m=1 and wreg_m==rs_d. fwd_b_d SHALL use the same rule with rt_d.
REQ-020 SHALL raise lwstall when memtoreg_e=1, wreg_e!=0 and wreg_e equals rs_d or rt_d.
REQ-021 SHALL raise brstall when branch_d=1 and either:
- regwrite_e=1 and nonzero wreg_e matches rs_d or rt_d, or
- memtoreg_m=1 and nonzero wreg_m matches rs_d or rt_d.
REQ-022 SHALL implement MDU FSM states IDLE and BUSY with a 4-bit down-counter.
REQ-023 In IDLE with mdu_start_e=1 and MDU_LAT>1, the FSM SHALL move to BUSY and load the counter with MDU_LAT-2.
REQ-024 In BUSY, the FSM SHALL decrement the counter each cycle and return to IDLE when the counter is 0.
REQ-025 SHALL ignore mdu_start_e while in BUSY.
REQ-026 With MDU_LAT=1, the FSM SHALL never leave IDLE.
REQ-027 SHALL assert mdu_busy combinationally when state==BUSY or (state==IDLE and mdu_start_e=1 and MDU_LAT>1).
REQ-028 SHALL raise mdustall when mdu_use_d=1 and mdu_busy=1.
REQ-029 SHALL set stall_f=stall_d=flush_e=lwstall|brstall|mdustall, all combinational with zero latency.
REQ-030 SHALL drive flush_d=pcsrc_d & ~stall_d; when a stall and a taken branch coincide, the stall SHALL win.

Reset
REQ-031 reset=0 SHALL immediately force state IDLE, counter 0 and stall counter 0; outputs then follow the inputs combinationally.
REQ-032 Reset asserted mid-BUSY SHALL abort the operation; mdu_busy SHALL be 0 once reset is released with no new mdu_start_e.

Configuration
REQ-033 With HAZARD_PERF_CNT_EN defined, the block SHALL add output perf_stall_cnt (CNT_W bits) counting cycles with stall_d=1 and saturating at all-ones. Without HAZARD_PERF_CNT_EN, the port and counter SHALL be absent.

Structure
REQ-034 Package pipeline_pkg SHALL hold the FSM state enum and the forward-select constants FWD_RF, FWD_W and FWD_M.
REQ-035 The MDU FSM and counter SHALL be sub-module mdu_tracker; forwarding and stall logic SHALL stay in the top.

Verification
REQ-036 Scenario: regwrite_m=1, wreg_m=5, regwrite_w=1, wreg_w=5, rs_e=5 -> fwd_a_e=10. Same with rs_e=0 -> fwd_a_e=00.
REQ-037 Scenario: memtoreg_e=1, wreg_e=7, rt_d=7 -> stall_f=stall_d=flush_e=1 for that cycle only.
REQ-038 Scenario: branch_d=1, regwrite_e=1, wreg_e=3, rs_d=3, pcsrc_d=1 -> stall_d=1, flush_d=0.
REQ-039 Scenario: MDU_LAT=4, mdu_start_e pulsed at cycle 0, mdu_use_d held high -> mdu_busy=1 for cycles 0..3 and stall_d=0 from cycle 4.
REQ-040 Scenario: reset=0 asserted in the 2nd BUSY cycle -> mdu_busy=0 immediately; with HAZARD_PERF_CNT_EN, perf_stall_cnt=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

    typedef enum logic [0:0] {
        MduIdle,
        MduBusy
    } mdu_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle; master is the datapath, slave is the controller.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REG_W = 5
);
    logic [REG_W-1:0] rs_d;
    logic [REG_W-1:0] rt_d;
    logic [REG_W-1:0] rs_e;
    logic [REG_W-1:0] rt_e;
    logic [REG_W-1:0] wreg_e;
    logic [REG_W-1:0] wreg_m;
    logic [REG_W-1:0] wreg_w;
    logic             regwrite_e;
    logic             regwrite_m;
    logic             regwrite_w;
    logic             memtoreg_e;
    logic             memtoreg_m;
    logic             branch_d;
    logic             pcsrc_d;
    logic             mdu_use_d;
    logic             mdu_start_e;

    logic             stall_f;
    logic             stall_d;
    logic             flush_d;
    logic             flush_e;
    logic             fwd_a_d;
    logic             fwd_b_d;
    logic [1:0]       fwd_a_e;
    logic [1:0]       fwd_b_e;
    logic             mdu_busy;

    modport master (
        output rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w,
        output regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m,
        output branch_d, pcsrc_d, mdu_use_d, mdu_start_e,
        input  stall_f, stall_d, flush_d, flush_e,
        input  fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, mdu_busy
    );

    modport slave (
        input  rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w,
        input  regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m,
        input  branch_d, pcsrc_d, mdu_use_d, mdu_start_e,
        output stall_f, stall_d, flush_d, flush_e,
        output fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, mdu_busy
    );

endinterface

// File: rtl/mdu_tracker.sv
// Tracks an in-flight multiply/divide so dependent D-stage instructions can be held.
module mdu_tracker
    import pipeline_pkg::*;
#(
    parameter int unsigned MDU_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic mdu_start_e,
    output logic mdu_busy
);

    localparam bit         MultiCycle = (MDU_LAT > 1);
    localparam logic [3:0] LoadVal    = MultiCycle ? 4'(MDU_LAT - 2) : 4'd0;

    mdu_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MduIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Start cycle already counts as busy, hence the load of MDU_LAT-2.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mdu_busy = 1'b0;
        unique case (state_q)
            MduIdle: begin
                if (mdu_start_e && MultiCycle) begin
                    state_d  = MduBusy;
                    cnt_d    = LoadVal;
                    mdu_busy = 1'b1;
                end
            end
            MduBusy: begin
                mdu_busy = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = MduIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = MduIdle;
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Forwarding, stall and flush control for a 5-stage pipeline with a multi-cycle MDU.
// Optional stall-cycle performance counter enabled by HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_W   = 5,
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]       perf_stall_cnt,
`endif
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam logic [REG_W-1:0] Zero = REG_W'(0);

    logic lwstall, brstall, mdustall, stall;
    logic mdu_busy;

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                           input logic rw_m, input logic [REG_W-1:0] wm,
                                           input logic rw_w, input logic [REG_W-1:0] ww);
        if (src != Zero && rw_m && wm == src) begin
            return FWD_M;
        end else if (src != Zero && rw_w && ww == src) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    assign hz.fwd_a_e = fwd_sel(hz.rs_e, hz.regwrite_m, hz.wreg_m, hz.regwrite_w, hz.wreg_w);
    assign hz.fwd_b_e = fwd_sel(hz.rt_e, hz.regwrite_m, hz.wreg_m, hz.regwrite_w, hz.wreg_w);

    assign hz.fwd_a_d = (hz.rs_d != Zero) && hz.regwrite_m && (hz.wreg_m == hz.rs_d);
    assign hz.fwd_b_d = (hz.rt_d != Zero) && hz.regwrite_m && (hz.wreg_m == hz.rt_d);

    always_comb begin
        lwstall = hz.memtoreg_e && (hz.wreg_e != Zero) &&
                  ((hz.wreg_e == hz.rs_d) || (hz.wreg_e == hz.rt_d));
        brstall = hz.branch_d &&
                  ((hz.regwrite_e && (hz.wreg_e != Zero) &&
                    ((hz.wreg_e == hz.rs_d) || (hz.wreg_e == hz.rt_d))) ||
                   (hz.memtoreg_m && (hz.wreg_m != Zero) &&
                    ((hz.wreg_m == hz.rs_d) || (hz.wreg_m == hz.rt_d))));
        mdustall = hz.mdu_use_d && mdu_busy;
        stall    = lwstall || brstall || mdustall;
    end

    assign hz.stall_f  = stall;
    assign hz.stall_d  = stall;
    assign hz.flush_e  = stall;
    // A stalled branch must not squash the instruction it is waiting on.
    assign hz.flush_d  = hz.pcsrc_d && !stall;
    assign hz.mdu_busy = mdu_busy;

    mdu_tracker #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu_tracker (
        .clk         (clk),
        .reset       (reset),
        .mdu_start_e (hz.mdu_start_e),
        .mdu_busy    (mdu_busy)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else if (stall && (perf_q != {CNT_W{1'b1}})) begin
            perf_q <= perf_q + CNT_W'(1);
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    if (CNT_W == 0) begin : g_no_cnt
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench: combinational vector table plus MDU and reset sequences.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned MDU_LAT = 4;
    localparam int unsigned CNT_W   = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_W(REG_W)) hif ();
    pipeline_hazard_ctrl_if #(.REG_W(REG_W)) hif1 ();

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf;
    logic [CNT_W-1:0] perf1;
`endif

    pipeline_hazard_ctrl #(
        .REG_W   (REG_W),
        .MDU_LAT (MDU_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cnt (perf),
`endif
        .hz             (hif)
    );

    // Single-cycle MDU variant: must never report busy.
    pipeline_hazard_ctrl #(
        .REG_W   (REG_W),
        .MDU_LAT (1),
        .CNT_W   (CNT_W)
    ) dut1 (
        .clk            (clk),
        .reset          (reset),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cnt (perf1),
`endif
        .hz             (hif1)
    );

    typedef struct {
        logic [4:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
        logic       rw_e, rw_m, rw_w, mtr_e, mtr_m, branch, pcsrc, mdu_use;
        logic       stall, flush, fa_d, fb_d;
        logic [1:0] fa_e, fb_e;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        hif.rs_d = '0; hif.rt_d = '0; hif.rs_e = '0; hif.rt_e = '0;
        hif.wreg_e = '0; hif.wreg_m = '0; hif.wreg_w = '0;
        hif.regwrite_e = 0; hif.regwrite_m = 0; hif.regwrite_w = 0;
        hif.memtoreg_e = 0; hif.memtoreg_m = 0; hif.branch_d = 0; hif.pcsrc_d = 0;
        hif.mdu_use_d = 0; hif.mdu_start_e = 0;
        hif1.rs_d = '0; hif1.rt_d = '0; hif1.rs_e = '0; hif1.rt_e = '0;
        hif1.wreg_e = '0; hif1.wreg_m = '0; hif1.wreg_w = '0;
        hif1.regwrite_e = 0; hif1.regwrite_m = 0; hif1.regwrite_w = 0;
        hif1.memtoreg_e = 0; hif1.memtoreg_m = 0; hif1.branch_d = 0; hif1.pcsrc_d = 0;
        hif1.mdu_use_d = 0; hif1.mdu_start_e = 0;
    endtask

    task automatic drive(input vec_t v);
        hif.rs_d = v.rs_d; hif.rt_d = v.rt_d; hif.rs_e = v.rs_e; hif.rt_e = v.rt_e;
        hif.wreg_e = v.wreg_e; hif.wreg_m = v.wreg_m; hif.wreg_w = v.wreg_w;
        hif.regwrite_e = v.rw_e; hif.regwrite_m = v.rw_m; hif.regwrite_w = v.rw_w;
        hif.memtoreg_e = v.mtr_e; hif.memtoreg_m = v.mtr_m;
        hif.branch_d = v.branch; hif.pcsrc_d = v.pcsrc; hif.mdu_use_d = v.mdu_use;
        hif.mdu_start_e = 0;
    endtask

    initial begin
        vecs[0]  = '{default: 0};
        vecs[1]  = '{rw_m: 1, wreg_m: 5, rw_w: 1, wreg_w: 5, rs_e: 5, fa_e: 2, default: 0};
        vecs[2]  = '{rw_m: 1, wreg_m: 5, rw_w: 1, wreg_w: 5, default: 0};
        vecs[3]  = '{rw_m: 1, wreg_m: 9, rw_w: 1, wreg_w: 6, rs_e: 6, rt_e: 6,
                     fa_e: 1, fb_e: 1, default: 0};
        vecs[4]  = '{wreg_m: 4, wreg_w: 4, rs_e: 4, rt_e: 4, default: 0};
        vecs[5]  = '{rw_m: 1, wreg_m: 8, rs_d: 8, rt_d: 8, fa_d: 1, fb_d: 1, default: 0};
        vecs[6]  = '{rw_m: 1, rw_w: 1, wreg_w: 3, rt_e: 3, fb_e: 1, default: 0};
        vecs[7]  = '{mtr_e: 1, rw_e: 1, wreg_e: 7, rt_d: 7, stall: 1, default: 0};
        vecs[8]  = '{mtr_e: 1, rw_e: 1, default: 0};
        vecs[9]  = '{branch: 1, rw_e: 1, wreg_e: 3, rs_d: 3, pcsrc: 1, stall: 1, default: 0};
        vecs[10] = '{branch: 1, pcsrc: 1, rs_d: 2, rt_d: 4, flush: 1, default: 0};
        vecs[11] = '{branch: 1, mtr_m: 1, wreg_m: 2, rt_d: 2, stall: 1, default: 0};
        vecs[12] = '{rw_e: 1, wreg_e: 3, rs_d: 3, pcsrc: 1, flush: 1, default: 0};
        vecs[13] = '{branch: 1, mtr_m: 1, rw_e: 1, default: 0};
        vecs[14] = '{mdu_use: 1, default: 0};
        vecs[15] = '{mtr_e: 1, wreg_e: 9, rs_d: 9, pcsrc: 1, stall: 1, default: 0};

        clear_inputs();
        reset = 1'b0;
        #2;
        check("reset mdu_busy", {31'd0, hif.mdu_busy}, 32'd0);
        check("reset stall_d", {31'd0, hif.stall_d}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("reset perf_stall_cnt", {16'd0, perf}, 32'd0);
`endif
        #10 reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d stall_f", i), {31'd0, hif.stall_f}, {31'd0, vecs[i].stall});
            check($sformatf("v%0d stall_d", i), {31'd0, hif.stall_d}, {31'd0, vecs[i].stall});
            check($sformatf("v%0d flush_e", i), {31'd0, hif.flush_e}, {31'd0, vecs[i].stall});
            check($sformatf("v%0d flush_d", i), {31'd0, hif.flush_d}, {31'd0, vecs[i].flush});
            check($sformatf("v%0d fwd_a_d", i), {31'd0, hif.fwd_a_d}, {31'd0, vecs[i].fa_d});
            check($sformatf("v%0d fwd_b_d", i), {31'd0, hif.fwd_b_d}, {31'd0, vecs[i].fb_d});
            check($sformatf("v%0d fwd_a_e", i), {30'd0, hif.fwd_a_e}, {30'd0, vecs[i].fa_e});
            check($sformatf("v%0d fwd_b_e", i), {30'd0, hif.fwd_b_e}, {30'd0, vecs[i].fb_e});
        end

        // MDU_LAT=1 instance with start and use held high.
        hif1.mdu_start_e = 1'b1;
        hif1.mdu_use_d   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #3;
            check($sformatf("lat1 c%0d mdu_busy", c), {31'd0, hif1.mdu_busy}, 32'd0);
            check($sformatf("lat1 c%0d stall_d", c), {31'd0, hif1.stall_d}, 32'd0);
        end
        hif1.mdu_start_e = 1'b0;

        // MDU_LAT=4 pulse at cycle 0; a second start in cycle 2 must be ignored.
        clear_inputs();
        hif.mdu_use_d = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 6; c++) begin
            hif.mdu_start_e = (c == 0 || c == 2);
            #3;
            check($sformatf("mdu c%0d mdu_busy", c), {31'd0, hif.mdu_busy},
                  (c <= 3) ? 32'd1 : 32'd0);
            check($sformatf("mdu c%0d stall_d", c), {31'd0, hif.stall_d},
                  (c <= 3) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end

        // Reset during the second BUSY cycle aborts the operation.
        hif.mdu_start_e = 1'b1;
        @(posedge clk);
        #1 hif.mdu_start_e = 1'b0;
        @(posedge clk);
        #1;
        check("rst pre mdu_busy", {31'd0, hif.mdu_busy}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("rst mdu_busy", {31'd0, hif.mdu_busy}, 32'd0);
        check("rst stall_d", {31'd0, hif.stall_d}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("rst perf_stall_cnt", {16'd0, perf}, 32'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #3;
            check($sformatf("post rst c%0d mdu_busy", c), {31'd0, hif.mdu_busy}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
